// File: rtl/add_and_or_unit64.sv
// add_and_or_unit64: registered 64-bit ADD/AND/OR slice for the execution stage.
// Three combinational sub-blocks share the same operands and a 2-bit opcode
// picks one of their results. A single output register stage adds one cycle
// of latency and carries valid, zero, carry and signed-overflow flags.

// ADD: 64-bit adder built from 16 cascaded 4-bit carry-lookahead groups.
// Inside each group the carries are looked ahead from generate/propagate.
// Between groups the carry ripples.
module ADD (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);
    logic [16:0] grp_c;

    assign grp_c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_grp
            logic [3:0] g;
            logic [3:0] p;
            logic [4:0] c;

            assign g    = a[4*gi +: 4] & b[4*gi +: 4];
            assign p    = a[4*gi +: 4] ^ b[4*gi +: 4];
            assign c[0] = grp_c[gi];
            assign c[1] = g[0] | (p[0] & c[0]);
            assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                        | (p[2] & p[1] & p[0] & c[0]);
            assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                        | (p[3] & p[2] & p[1] & g[0])
                        | (p[3] & p[2] & p[1] & p[0] & c[0]);

            assign sum[4*gi +: 4] = p ^ c[3:0];
            assign grp_c[gi+1]    = c[4];
        end
    endgenerate

    assign cout = grp_c[16];
endmodule

// AND_64_bit: bitwise AND of the two operands.
module AND_64_bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] and_ab
);
    assign and_ab = a & b;
endmodule

// OR_64_bit: bitwise OR of the two operands.
module OR_64_bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] or_ab
);
    assign or_ab = a | b;
endmodule

module add_and_or_unit64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid
);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;

    logic signed [WIDTH-1:0] a_s_p0;
    logic signed [WIDTH-1:0] b_s_p0;
    logic signed [WIDTH-1:0] sum_p0;
    logic        [WIDTH-1:0] and_p0;
    logic        [WIDTH-1:0] or_p0;
    logic                    add_cout_p0;
    logic        [WIDTH-1:0] result_p0;
    logic                    cout_p0;
    logic                    ovf_p0;
    logic                    zero_p0;

    // Two's-complement overflow: like-signed operands giving an opposite-signed sum.
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign a_s_p0 = a;
    assign b_s_p0 = b;

    ADD u_add (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum_p0),
        .cout (add_cout_p0)
    );

    AND_64_bit u_and (
        .a      (a),
        .b      (b),
        .and_ab (and_p0)
    );

    OR_64_bit u_or (
        .a     (a),
        .b     (b),
        .or_ab (or_p0)
    );

    // Stage p0: select the result by opcode and derive the flags from it.
    always_comb begin
        result_p0 = '0;
        cout_p0   = 1'b0;
        ovf_p0    = 1'b0;
        case (op)
            OP_ADD: begin
                result_p0 = sum_p0;
                cout_p0   = add_cout_p0;
                ovf_p0    = add_ovf(a_s_p0, b_s_p0, sum_p0);
            end
            OP_AND:  result_p0 = and_p0;
            OP_OR:   result_p0 = or_p0;
            default: result_p0 = '0;
        endcase
        zero_p0 = (result_p0 == '0);
    end

    // Output register: capture on in_valid, otherwise hold data and drop out_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= result_p0;
                cout   <= cout_p0;
                ovf    <= ovf_p0;
                zero   <= zero_p0;
            end
        end
    end
endmodule

// File: tb/tb_add_and_or_unit64.sv
// Directed bench for add_and_or_unit64: reset behaviour, a vector table of
// ADD/AND/OR/reserved operations, back-to-back streaming and mid-stream reset.
module tb_add_and_or_unit64;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] result;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        out_valid;

    int total;
    int bad;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] exp_result;
        logic        exp_cout;
        logic        exp_ovf;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[11];

    add_and_or_unit64 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [63:0] r, input logic c,
                           input logic o, input logic z, input logic v);
        chk({name, ".result"},    result,    r);
        chk({name, ".cout"},      {63'd0, cout},      {63'd0, c});
        chk({name, ".ovf"},       {63'd0, ovf},       {63'd0, o});
        chk({name, ".zero"},      {63'd0, zero},      {63'd0, z});
        chk({name, ".out_valid"}, {63'd0, out_valid}, {63'd0, v});
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [63:0] x,
                         input logic [63:0] y, input logic c);
        @(negedge clk);
        in_valid = v;
        op       = o;
        a        = x;
        b        = y;
        cin      = c;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //           op     a                      b                      cin   result                 cout  ovf   zero
        vecs[0]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                 1'b0, 64'h0,                 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,                 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{2'b00, 64'h5,                 64'h7,                 1'b1, 64'hD,                 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{2'b00, 64'h0,                 64'h0,                 1'b1, 64'h1,                 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{2'b01, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 64'hF000_F000_F000_F000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{2'b10, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_FF00, 1'b0, 64'hFFFF,              1'b0, 1'b0, 1'b0};
        vecs[6]  = '{2'b11, 64'h1234,              64'h5678,              1'b1, 64'h0,                 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                 1'b1, 64'h0,                 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0,                 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'h0,                 1'b0, 1'b0, 1'b1};

        // Reset held low with a live operation on the inputs.
        reset    = 1'b0;
        in_valid = 1'b1;
        op       = 2'b00;
        a        = 64'h5;
        b        = 64'h7;
        cin      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_all("reset_hold", 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_all("reset_release", 64'hC, 1'b0, 1'b0, 1'b0, 1'b1);

        // Vector table.
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].exp_result, vecs[i].exp_cout,
                    vecs[i].exp_ovf, vecs[i].exp_zero, 1'b1);
        end

        // Back-to-back ADD, AND, OR, then an idle cycle with junk inputs.
        drive(1'b1, 2'b00, 64'h3, 64'h4, 1'b0);
        @(posedge clk);
        #1;
        chk_all("stream_add", 64'h7, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 2'b01, 64'hC, 64'hA, 1'b1);
        @(posedge clk);
        #1;
        chk_all("stream_and", 64'h8, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 2'b10, 64'hC, 64'hA, 1'b0);
        @(posedge clk);
        #1;
        chk_all("stream_or", 64'hE, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
        @(posedge clk);
        #1;
        chk_all("stream_idle", 64'hE, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("stream_idle2", 64'hE, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset asserted mid-stream acts immediately and discards the in-flight op.
        drive(1'b1, 2'b00, 64'h1, 64'h1, 1'b0);
        @(posedge clk);
        #1;
        chk_all("mid_pre", 64'h2, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 2'b10, 64'hF0, 64'h0F, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_all("mid_async", 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk_all("mid_held", 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_all("mid_after", 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/add_and_or_unit64.md
Name: add_and_or_unit64

Overview:
- Registered 64-bit arithmetic/logic slice for the datapath execution stage.
- Provides ADD with carry-in/carry-out, bitwise AND and bitwise OR, selected by a 2-bit opcode.
- Internally instantiates three combinational sub-blocks with these port lists:
  - ADD (a, b, cin, sum, cout)
  - AND_64_bit (a, b, and_ab)
  - OR_64_bit (a, b, or_ab)
- A result register adds one cycle of latency plus valid/zero/carry/overflow flags.

Parameters:
- WIDTH, 64, operand and result width. Sub-blocks are fixed at 64; WIDTH is not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  operands/op presented this cycle are captured.
- op  input  2  00=ADD, 01=AND, 10=OR, 11=reserved.
- a  input  64  operand A.
- b  input  64  operand B.
- cin  input  1  carry-in, used by ADD only.
- result  output  64  registered result.
- cout  output  1  registered carry-out of ADD; 0 for other ops.
- ovf  output  1  registered signed overflow of ADD; 0 for other ops.
- zero  output  1  registered, 1 when result == 0.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Reset:
  - reset=0 asynchronously forces result=0, cout=0, ovf=0, zero=1, out_valid=0.
  - Outputs hold these values while reset is low.
  - The first capture is on the first rising clk edge after reset goes high.
- ADD sub-block:
  - sum = (a + b + cin) mod 2^64; cout = bit 64 of the full sum.
  - Built as 16 cascaded 4-bit carry-lookahead groups: per bit, generate g=a&b and propagate p=a^b; group carries ripple between groups.
  - Purely combinational, no clock.
- AND_64_bit: and_ab = a & b, bitwise.
- OR_64_bit: or_ab = a | b, bitwise.
- Operand routing: all three sub-blocks see the same a and b every cycle.
- Output select mux:
  - op=00: sum.
  - op=01: and_ab.
  - op=10: or_ab.
  - op=11: 64'h0.
- Flags:
  - ovf = (a[63]==b[63]) && (sum[63]!=a[63]), for ADD only.
  - cout and ovf are forced to 0 for op != 00.
  - zero is computed from the selected next result.
- Capture:
  - On a rising clk edge with in_valid=1, register result, cout, ovf and zero; set out_valid=1.
  - On a rising clk edge with in_valid=0: result, cout, ovf and zero hold their previous values; out_valid=0.
- Latency: exactly one cycle, in_valid -> out_valid; throughput of one operation per cycle.
- Back-to-back operations are allowed with no bubbles.
- Boundaries:
  - a=all ones, b=0, cin=1 wraps to 0 with cout=1.
  - cin is ignored for AND/OR.
  - X on unused inputs must not propagate when in_valid=0.
- Reset asserted mid-stream: the in-flight result is discarded and out_valid is 0 on the next sample.
- No internal state beyond the output registers.

Test Plan:
- Hold reset=0 for 3 cycles with in_valid=1, op=00, a=5, b=7 -> result=0, cout=0, zero=1, out_valid=0 throughout. Release reset -> next edge gives result=0xC, out_valid=1.
- ADD a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> result=0, cout=1, zero=1, ovf=0. Then a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result=0x8000_0000_0000_0000, ovf=1, cout=0.
- ADD a=5, b=7, cin=1 -> result=0xD, cout=0, zero=0. Then a=0, b=0, cin=1 -> result=1.
- AND a=0xF0F0_F0F0_F0F0_F0F0, b=0xFF00_FF00_FF00_FF00, cin=1 -> result=0xF000_F000_F000_F000, cout=0, ovf=0.
- OR a=0x0000_0000_0000_00FF, b=0x0000_0000_0000_FF00 -> result=0xFFFF. Then op=11 -> result=0, zero=1.
- Stream ADD, AND, OR on consecutive cycles, then in_valid=0 -> results appear one cycle later in order; out_valid drops and result holds the OR value.
